// File: rtl/subparser_dispatcher.sv
// Dispatches one command to the selected subparser, muxes the shared character FIFO
// to it while it runs, and reports the latched result with a watchdog fallback.
module subparser_dispatcher #(
    parameter int unsigned NUM_SUB  = 4,
    parameter int unsigned CMD_BITS = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic [CMD_BITS-1:0]        cmd,
    output logic                       rdy,
    output logic                       done,
    output logic                       success,
    output logic                       newline,
    output logic                       timeout,
    output logic                       bad_cmd,
    output logic [$clog2(NUM_SUB)-1:0] sel,
    output logic [NUM_SUB-1:0]         sub_trigger,
    input  logic [NUM_SUB-1:0]         sub_done,
    input  logic [NUM_SUB-1:0]         sub_rdy,
    input  logic [NUM_SUB-1:0]         sub_success,
    input  logic [NUM_SUB-1:0]         sub_newline,
    input  logic [NUM_SUB-1:0]         sub_rd_trigger,
    output logic [NUM_SUB-1:0]         sub_rd_done,
    output logic [NUM_SUB-1:0]         sub_rd_rdy,
    output logic [NUM_SUB-1:0]         sub_is_empty,
    output logic                       fifo_rd_trigger,
    input  logic                       fifo_rd_done,
    input  logic                       fifo_rd_rdy,
    input  logic                       fifo_is_empty
);

    localparam int unsigned SEL_W = $clog2(NUM_SUB);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, TRIG, BUSY, FINISH} state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              success_q, success_d;
    logic              newline_q, newline_d;
    logic              timeout_q, timeout_d;
    logic              bad_cmd_q, bad_cmd_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            wd_q      <= '0;
            success_q <= 1'b0;
            newline_q <= 1'b0;
            timeout_q <= 1'b0;
            bad_cmd_q <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wd_q      <= wd_d;
            success_q <= success_d;
            newline_q <= newline_d;
            timeout_q <= timeout_d;
            bad_cmd_q <= bad_cmd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wd_d        = wd_q;
        success_d   = success_q;
        newline_d   = newline_q;
        timeout_d   = timeout_q;
        bad_cmd_d   = bad_cmd_q;
        sub_trigger = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    success_d = 1'b0;
                    newline_d = 1'b0;
                    timeout_d = 1'b0;
                    bad_cmd_d = 1'b0;
                    sel_d     = cmd[SEL_W-1:0];
                    if (32'(cmd) >= NUM_SUB) begin
                        bad_cmd_d = 1'b1;
                        state_d   = FINISH;
                    end else begin
                        state_d   = TRIG;
                    end
                end
            end
            TRIG: begin
                // Trigger is combinational so the subparser sees it in the same cycle rdy is seen.
                if (sub_rdy[sel_q]) begin
                    sub_trigger[sel_q] = 1'b1;
                    wd_d               = '0;
                    state_d            = BUSY;
                end
            end
            BUSY: begin
                if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
                if (sub_done[sel_q]) begin
                    success_d = sub_success[sel_q];
                    newline_d = sub_newline[sel_q];
                    state_d   = FINISH;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    success_d = 1'b0;
                    state_d   = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO view is only lent to the selected subparser while it is running.
    always_comb begin
        fifo_rd_trigger = 1'b0;
        sub_rd_done     = '0;
        sub_rd_rdy      = '0;
        sub_is_empty    = '1;
        if (state_q == BUSY) begin
            fifo_rd_trigger      = sub_rd_trigger[sel_q];
            sub_rd_done[sel_q]   = fifo_rd_done;
            sub_rd_rdy[sel_q]    = fifo_rd_rdy;
            sub_is_empty[sel_q]  = fifo_is_empty;
        end
    end

    assign rdy     = (state_q == IDLE);
    assign done    = (state_q == FINISH);
    assign success = success_q;
    assign newline = newline_q;
    assign timeout = timeout_q;
    assign bad_cmd = bad_cmd_q;
    assign sel     = sel_q;

endmodule

// File: tb/tb_subparser_dispatcher.sv
// Scoreboard bench for subparser_dispatcher: directed commands push expected results,
// a negedge monitor checks every done pulse, trigger activity and start-to-done latency.
module tb_subparser_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_en = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cmd = '0;
    logic       rdy, done, success, newline, timeout, bad_cmd;
    logic [1:0] sel;
    logic [3:0] sub_trigger;
    logic [3:0] sub_done;
    logic [3:0] sub_rdy = '1;
    logic [3:0] sub_success = '0;
    logic [3:0] sub_newline = '0;
    logic [3:0] sub_rd_trigger = '0;
    logic [3:0] sub_rd_done, sub_rd_rdy, sub_is_empty;
    logic       fifo_rd_trigger;
    logic       fifo_rd_done = 1'b0;
    logic       fifo_rd_rdy = 1'b0;
    logic       fifo_is_empty = 1'b1;

    logic [3:0] resp_done;
    logic [3:0] noise = '0;
    int         resp_delay = 1;
    logic       en_toggle = 1'b0;
    assign sub_done = resp_done | noise;

    typedef struct {
        logic [3:0] trig;
        logic       succ, nl, to, bad;
        logic [1:0] sel;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   n_total = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    subparser_dispatcher #(.NUM_SUB(4), .CMD_BITS(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .cmd(cmd),
        .rdy(rdy), .done(done), .success(success), .newline(newline),
        .timeout(timeout), .bad_cmd(bad_cmd), .sel(sel),
        .sub_trigger(sub_trigger), .sub_done(sub_done), .sub_rdy(sub_rdy),
        .sub_success(sub_success), .sub_newline(sub_newline),
        .sub_rd_trigger(sub_rd_trigger), .sub_rd_done(sub_rd_done),
        .sub_rd_rdy(sub_rd_rdy), .sub_is_empty(sub_is_empty),
        .fifo_rd_trigger(fifo_rd_trigger), .fifo_rd_done(fifo_rd_done),
        .fifo_rd_rdy(fifo_rd_rdy), .fifo_is_empty(fifo_is_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] trig, input logic s, input logic n,
                                input logic t, input logic b, input logic [1:0] sl, input int lat);
        exp_t e;
        e.trig = trig; e.succ = s; e.nl = n; e.to = t; e.bad = b; e.sel = sl; e.lat = lat;
        return e;
    endfunction

    // clk_en driver: steady high, or alternating when en_toggle is set
    initial forever begin
        @(posedge clk); #1;
        clk_en = en_toggle ? ~clk_en : 1'b1;
    end

    // Subparser responder: sub_done on the triggered bit resp_delay enabled cycles after trigger
    initial begin
        logic       en, rst;
        logic [3:0] trg;
        int         pend, idx;
        resp_done = '0; pend = 0; idx = 0;
        forever begin
            @(negedge clk);
            en = clk_en; trg = sub_trigger; rst = reset;
            @(posedge clk); #1;
            if (rst) begin
                resp_done = '0; pend = 0;
            end else if (en) begin
                resp_done = '0;
                if (trg != 0) begin
                    for (int k = 0; k < 4; k++) if (trg[k]) idx = k;
                    pend = resp_delay;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) resp_done[idx] = 1'b1;
                end
            end
        end
    end

    // Monitor: counts enabled cycles, tracks triggers, checks each done against the scoreboard
    initial begin
        int         ecyc, trig_cnt, s;
        logic [3:0] trig_or;
        exp_t       e;
        ecyc = 0; trig_cnt = 0; trig_or = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                start_q.delete(); trig_or = '0; trig_cnt = 0;
            end else if (clk_en) begin
                ecyc++;
                if (start && rdy) start_q.push_back(ecyc);
                if (sub_trigger != 0) begin
                    trig_or |= sub_trigger;
                    trig_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        s = (start_q.size() > 0) ? start_q.pop_front() : ecyc + 100;
                        check("trig_bits", int'(trig_or), int'(e.trig));
                        check("trig_pulses", trig_cnt, (e.trig != 0) ? 1 : 0);
                        check("success", int'(success), int'(e.succ));
                        check("newline", int'(newline), int'(e.nl));
                        check("timeout", int'(timeout), int'(e.to));
                        check("bad_cmd", int'(bad_cmd), int'(e.bad));
                        check("sel", int'(sel), int'(e.sel));
                        check("latency", ecyc - s + 1, e.lat);
                    end
                    trig_or = '0; trig_cnt = 0;
                end
            end
        end
    end

    task automatic en_edge();
        logic e;
        int   g;
        g = 0;
        do begin
            @(negedge clk); e = clk_en;
            @(posedge clk); #1;
            g++;
        end while (!e && g < 100);
    endtask

    task automatic issue(input logic [3:0] c, input bit push, input exp_t e);
        int g;
        g = 0;
        while (!rdy && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (!rdy) check("rdy_before_start", int'(rdy), 1);
        start = 1'b1; cmd = c;
        if (push) exp_q.push_back(e);
        en_edge();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !rdy) && g < 400) begin
            @(posedge clk); #1; g++;
        end
        check("idle_wait_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int dc;
        exp_t none;
        none = mk(4'b0000, 0, 0, 0, 0, 2'd0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", int'(rdy), 1);
        check("rst_done", int'(done), 0);
        check("rst_flags", int'({success, newline, timeout, bad_cmd}), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_sub_trigger", int'(sub_trigger), 0);
        check("rst_fifo_trigger", int'(fifo_rd_trigger), 0);
        check("rst_is_empty", int'(sub_is_empty), 15);
        reset = 1'b0;
        @(posedge clk); #1;

        // basic dispatch to subparser 1
        resp_delay = 1; sub_success = 4'b0010; sub_newline = 4'b0000;
        issue(4'd1, 1, mk(4'b0010, 1, 0, 0, 0, 2'd1, 4));
        wait_idle();

        // subparser 3 with newline; unselected sub_done must be ignored
        sub_success = 4'b0001; sub_newline = 4'b1000; noise = 4'b0001;
        issue(4'd3, 1, mk(4'b1000, 0, 1, 0, 0, 2'd3, 4));
        wait_idle();
        noise = '0;

        // out-of-range commands
        issue(4'd9, 1, mk(4'b0000, 0, 0, 0, 1, 2'd1, 2));
        wait_idle();
        issue(4'd4, 1, mk(4'b0000, 0, 0, 0, 1, 2'd0, 2));
        wait_idle();

        // watchdog expiry on subparser 2, FIFO routing checks while BUSY, start ignored
        resp_delay = 0; sub_success = 4'b1111;
        issue(4'd2, 1, mk(4'b0100, 0, 0, 1, 0, 2'd2, 11));
        en_edge();
        sub_rd_trigger = 4'b0110; fifo_rd_rdy = 1'b1; fifo_rd_done = 1'b1; fifo_is_empty = 1'b0;
        #1;
        check("busy_rdy", int'(rdy), 0);
        check("route_fifo_trigger", int'(fifo_rd_trigger), 1);
        check("route_rd_rdy", int'(sub_rd_rdy), 4);
        check("route_rd_done", int'(sub_rd_done), 4);
        check("route_is_empty", int'(sub_is_empty), 11);
        fifo_is_empty = 1'b1; sub_rd_trigger = 4'b1011;
        #1;
        check("route_is_empty_follow", int'(sub_is_empty), 15);
        check("route_unselected_trig", int'(fifo_rd_trigger), 0);
        sub_rd_trigger = '0; fifo_rd_rdy = 1'b0; fifo_rd_done = 1'b0;
        en_edge();
        start = 1'b1; cmd = 4'd9;
        en_edge();
        start = 1'b0;
        wait_idle();

        // sub_done on the last watchdog cycle wins over timeout
        resp_delay = 8; sub_success = 4'b0001; sub_newline = 4'b0001;
        issue(4'd0, 1, mk(4'b0001, 1, 1, 0, 0, 2'd0, 11));
        wait_idle();

        // sub_rdy held low for three enabled cycles
        resp_delay = 1; sub_success = 4'b0010; sub_newline = 4'b0000; sub_rdy = 4'b1101;
        issue(4'd1, 1, mk(4'b0010, 1, 0, 0, 0, 2'd1, 7));
        en_edge(); en_edge(); en_edge();
        sub_rdy = '1;
        wait_idle();

        // clk_en toggling: same per-enabled-cycle behaviour
        en_toggle = 1'b1;
        issue(4'd1, 1, mk(4'b0010, 1, 0, 0, 0, 2'd1, 4));
        wait_idle();
        issue(4'd6, 1, mk(4'b0000, 0, 0, 0, 1, 2'd2, 2));
        wait_idle();
        en_toggle = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // reset while BUSY abandons the dispatch silently
        resp_delay = 0;
        issue(4'd3, 0, none);
        en_edge();
        sub_rd_trigger = '1;
        #1;
        check("pre_reset_fifo_trigger", int'(fifo_rd_trigger), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_reset_rdy", int'(rdy), 1);
        check("post_reset_done", int'(done), 0);
        check("post_reset_sub_trigger", int'(sub_trigger), 0);
        check("post_reset_fifo_trigger", int'(fifo_rd_trigger), 0);
        check("post_reset_sel", int'(sel), 0);
        sub_rd_trigger = '0;
        dc = done_cnt;
        repeat (20) begin
            @(posedge clk); #1;
        end
        check("no_done_after_reset", done_cnt, dc);

        // normal operation resumes
        resp_delay = 1; sub_success = 4'b0000; sub_newline = 4'b0100;
        issue(4'd2, 1, mk(4'b0100, 0, 1, 0, 0, 2'd2, 4));
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/subparser_dispatcher.md
SUBPARSER_DISPATCHER -- requirements
Module: subparser_dispatcher

Interface
REQ-001 SHALL have parameter NUM_SUB, default 4: number of attached command subparsers (linear, arc, etc.), at least 2.
REQ-002 SHALL have parameter CMD_BITS, default 4: width of the opcode cmd field.
REQ-003 SHALL have parameter TIMEOUT, default 1024: watchdog limit in clk_en cycles.
REQ-004 SHALL have clk  input  1  system clock, rising-edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have clk_en  input  1  global enable; all state advances only when high.
REQ-007 SHALL have start  input  1  request to dispatch one command.
REQ-008 SHALL have cmd  input  CMD_BITS  command code; value k selects subparser k.
REQ-009 SHALL have rdy  output  1  high in IDLE.
REQ-010 SHALL have done  output  1  one-cycle completion pulse.
REQ-011 SHALL have success, newline, timeout, bad_cmd  output  1 each  latched result flags, valid from done until next start.
REQ-012 SHALL have sel  output  $clog2(NUM_SUB)  latched subparser index.
REQ-013 SHALL have sub_trigger, sub_done, sub_rdy, sub_success, sub_newline  trigger output / others input  NUM_SUB each  per-subparser handshake.
REQ-014 SHALL have sub_rd_trigger  input  NUM_SUB; sub_rd_done, sub_rd_rdy, sub_is_empty  output  NUM_SUB each  per-subparser char-FIFO view.
REQ-015 SHALL have fifo_rd_trigger  output  1; fifo_rd_done, fifo_rd_rdy, fifo_is_empty  input  1 each  shared char FIFO port.

Function
REQ-016 SHALL implement FSM states IDLE, TRIG, BUSY, FINISH; all transitions and register updates gated by clk_en.
REQ-017 SHALL, in IDLE with start=1: clear all result flags, latch sel=cmd[$clog2(NUM_SUB)-1:0]; go FINISH with bad_cmd=1 if cmd>=NUM_SUB, else TRIG.
REQ-018 SHALL ignore start in any state other than IDLE.
REQ-019 SHALL, in TRIG, wait while sub_rdy[sel]=0; when high, assert sub_trigger[sel] for exactly one clk_en cycle and go BUSY; no other sub_trigger bit ever asserts.
REQ-020 SHALL, only in BUSY, route fifo_rd_trigger=sub_rd_trigger[sel] and drive sub_rd_done[sel], sub_rd_rdy[sel], sub_is_empty[sel] from the FIFO inputs combinationally (zero latency).
REQ-021 SHALL drive unselected bits, and all bits outside BUSY, to rd_done=0, rd_rdy=0, is_empty=1; fifo_rd_trigger=0 outside BUSY.
REQ-022 SHALL clear the watchdog on entering BUSY and increment it once per clk_en cycle spent in BUSY.
REQ-023 SHALL, in BUSY on sub_done[sel]=1, latch success=sub_success[sel], newline=sub_newline[sel] and go FINISH.
REQ-024 SHALL, in BUSY when the watchdog reaches TIMEOUT-1 without sub_done[sel], set timeout=1, success=0 and go FINISH.
REQ-025 SHALL give sub_done priority over timeout when both occur in the same cycle.
REQ-026 SHALL, in FINISH, assert done for one clk_en cycle and return to IDLE; done is a Moore output of FINISH.
REQ-027 SHALL ignore sub_done from unselected subparsers.
REQ-028 SHALL size the watchdog $clog2(TIMEOUT+1) bits with no wrap.
REQ-029 SHALL produce minimum start-to-done latency of 4 clk_en cycles for a valid cmd with immediate sub_rdy and sub_done one cycle after trigger, and 2 cycles for a bad cmd.

Reset
REQ-030 SHALL, on reset (takes effect regardless of clk_en), enter IDLE with rdy=1, done=0, success=0, newline=0, timeout=0, bad_cmd=0, sel=0, watchdog=0, sub_trigger=0, fifo_rd_trigger=0.
REQ-031 SHALL abandon any in-flight dispatch on reset without emitting done.

Verification
REQ-032 SHALL cover: cmd=1, sub_rdy=all 1, sub_done[1]+sub_success[1] one cycle after trigger -> one sub_trigger[1] pulse, done with success=1, sel=1, latency 4.
REQ-033 SHALL cover: cmd=2 in BUSY, sub_rd_trigger=4'b0110 -> fifo_rd_trigger=1; fifo_rd_rdy=1 visible only on sub_rd_rdy[2]; sub_is_empty=4'b1111 except bit 2 following the FIFO.
REQ-034 SHALL cover: cmd=9 with NUM_SUB=4 -> no sub_trigger, done with bad_cmd=1, success=0, 2 cycles after start.
REQ-035 SHALL cover: TIMEOUT=8, sub_done never -> done with timeout=1, success=0 exactly 8 BUSY cycles after entry; sub_done at that same cycle -> timeout=0.
REQ-036 SHALL cover: clk_en toggling 1/0 during full dispatch -> identical outputs per enabled cycle; start while BUSY ignored.
REQ-037 SHALL cover: reset asserted in BUSY -> next cycle rdy=1, all triggers 0, no done pulse.
